// File: rtl/prng_pkg.sv
// prng_pkg: shared FSM encoding, default tap masks and helpers for the LFSR PRNG.
// Contents: fsm_t (IDLE/GEN/HOLD), maximal-length XNOR tap masks for 8/16/24/32 bits,
// all_ones(width) returning a 32-bit mask with the low width bits set.
package prng_pkg;
  typedef enum logic [1:0] {IDLE, GEN, HOLD} fsm_t;
  localparam logic [7:0]  TAPS_8  = 8'hB8;
  localparam logic [15:0] TAPS_16 = 16'hD008;
  localparam logic [23:0] TAPS_24 = 24'hE1_0000;
  localparam logic [31:0] TAPS_32 = 32'h8020_0003;
  function automatic logic [31:0] all_ones(input int width);
    return 32'((64'd1 << width) - 64'd1);
  endfunction
endpackage

// File: rtl/prng_prescaler.sv
// prng_prescaler: clock-enable tick generator, one tick every cfg_div+1 running cycles.
// Ports: CLK, rst (async active-low), clr (sync clear), run (count enable),
// cfg_div (period minus 1), tick (high in the cycle the count equals cfg_div).
module prng_prescaler #(
  parameter int DIV_W = 24
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic             clr,
  input  logic             run,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             tick
);
  logic [DIV_W-1:0] cnt;
  // Compared live against cfg_div, so a new period applies at the next compare.
  assign tick = run & ~clr & (cnt == cfg_div);
  always_ff @(posedge CLK or negedge rst)
    if (!rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (run) cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/lfsr_prng_core.sv
// lfsr_prng_core: XNOR Fibonacci LFSR word generator with prescaler, seed load, lock-up guard and valid/ready output.
// Ports: CLK, rst (async active-low), en, mode (0 free-run / 1 single-step), step,
// cfg_div, cfg_load, cfg_seed, out_data, out_valid, out_ready, lock_err, busy.
module lfsr_prng_core
  import prng_pkg::*;
#(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(TAPS_16),
  parameter int               OUT_W = 8,
  parameter int               DIV_W = 24,
  parameter logic [WIDTH-1:0] SEED  = '0
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic             step,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             cfg_load,
  input  logic [WIDTH-1:0] cfg_seed,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             lock_err,
  output logic             busy
);
  localparam int               BC_W = $clog2(OUT_W + 1);
  localparam logic [BC_W-1:0]  LAST = BC_W'(OUT_W - 1);
  localparam logic [WIDTH-1:0] ONES = WIDTH'(all_ones(WIDTH));
  fsm_t             st, nx;
  logic [WIDTH-1:0] lfsr, cand, nxt;
  logic [BC_W-1:0]  bit_cnt;
  logic             fb, bad, tick, clr, wr, last;
  // Load and shift share one write path so the all-ones guard covers both.
  always_comb begin
    fb   = ~^(lfsr & TAPS);
    cand = cfg_load ? cfg_seed : {lfsr[WIDTH-2:0], fb};
    bad  = cand == ONES;
    nxt  = bad ? SEED : cand;
    wr   = cfg_load | tick;
    last = bit_cnt == LAST;
    clr  = cfg_load | ~en | (st != GEN);
  end
  // tick is suppressed by clr, so a coinciding load never also shifts.
  prng_prescaler #(.DIV_W(DIV_W)) u_presc (
    .CLK     (CLK),
    .rst     (rst),
    .clr     (clr),
    .run     (st == GEN),
    .cfg_div (cfg_div),
    .tick    (tick)
  );
  always_ff @(posedge CLK or negedge rst)
    if (!rst) st <= IDLE;
    else st <= nx;
  always_comb
    nx = (cfg_load || !en) ? IDLE
       : (st == IDLE) ? ((!mode || step) ? GEN : IDLE)
       : (st == GEN)  ? ((tick && last) ? HOLD : GEN)
       : (st == HOLD) ? ((out_valid && out_ready) ? (mode ? IDLE : GEN) : HOLD)
       : IDLE;
  always_comb busy = st == GEN;
  always_ff @(posedge CLK or negedge rst)
    if (!rst) begin
      lfsr      <= SEED;
      bit_cnt   <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      lock_err  <= 1'b0;
    end else begin
      lock_err <= wr & bad;
      if (wr) lfsr <= nxt;
      if (cfg_load || !en) begin
        bit_cnt   <= '0;
        out_valid <= 1'b0;
      end else if (tick) begin
        bit_cnt <= last ? '0 : bit_cnt + 1'b1;
        if (last) begin
          out_data  <= nxt[OUT_W-1:0];
          out_valid <= 1'b1;
        end
      end else if (st == HOLD && out_valid && out_ready) out_valid <= 1'b0;
    end
endmodule

// File: tb/tb_lfsr_prng_core.sv
// tb_lfsr_prng_core: directed table-driven and sequence checks of lfsr_prng_core with default parameters.
module tb_lfsr_prng_core;
  logic        CLK = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0, mode = 1'b0, step = 1'b0, cfg_load = 1'b0, out_ready = 1'b0;
  logic [23:0] cfg_div = '0;
  logic [15:0] cfg_seed = '0;
  logic [7:0]  out_data;
  logic        out_valid, lock_err, busy;
  int          total = 0, bad = 0;
  always #5 CLK = ~CLK;
  lfsr_prng_core dut (
    .CLK       (CLK),
    .rst       (rst),
    .en        (en),
    .mode      (mode),
    .step      (step),
    .cfg_div   (cfg_div),
    .cfg_load  (cfg_load),
    .cfg_seed  (cfg_seed),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .lock_err  (lock_err),
    .busy      (busy)
  );
  typedef struct {
    logic [23:0] div;
    int          lat;
    logic [7:0]  w1;
    int          gap;
    logic [7:0]  w2;
  } vec_t;
  vec_t tbl[3];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask
  task automatic do_reset();
    en = 0; mode = 0; step = 0; cfg_load = 0; cfg_seed = '0; cfg_div = '0; out_ready = 0;
    rst = 0;
    cyc(1);
    rst = 1;
    cyc(1);
  endtask
  task automatic wait_valid(input int lim, output int n);
    n = -1;
    for (int i = 1; i <= lim; i++) begin
      @(posedge CLK);
      #1;
      if (out_valid) begin
        n = i;
        break;
      end
    end
  endtask
  initial begin
    int n, errs;
    logic [15:0] exp_s[4];
    tbl[0] = '{div: 24'd0, lat: 9,  w1: 8'hF0, gap: 9,  w2: 8'hF6};
    tbl[1] = '{div: 24'd1, lat: 17, w1: 8'hF0, gap: 17, w2: 8'hF6};
    tbl[2] = '{div: 24'd3, lat: 33, w1: 8'hF0, gap: 33, w2: 8'hF6};
    exp_s = '{16'h0000, 16'h0001, 16'h0003, 16'h0007};
    #3;
    chk("rst_data", 32'(out_data), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_lock", 32'(lock_err), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_state", 32'(dut.lfsr), 0);
    foreach (tbl[k]) begin
      do_reset();
      cfg_div = tbl[k].div; out_ready = 1; en = 1;
      wait_valid(200, n);
      chk("tbl_lat", n, tbl[k].lat);
      chk("tbl_w1", 32'(out_data), 32'(tbl[k].w1));
      chk("tbl_hold_busy", 32'(busy), 0);
      wait_valid(200, n);
      chk("tbl_gap", n, tbl[k].gap);
      chk("tbl_w2", 32'(out_data), 32'(tbl[k].w2));
      chk("tbl_state2", 32'(dut.lfsr), 32'h0000F0F6);
    end
    do_reset();
    cfg_div = 3; out_ready = 1; en = 1;
    errs = 0;
    for (int i = 1; i <= 12; i++) begin
      cyc(1);
      if (dut.lfsr !== exp_s[(i - 1) / 4]) errs++;
    end
    chk("div3_every4", errs, 0);
    do_reset();
    en = 1;
    wait_valid(50, n);
    chk("stall_w1", 32'(out_data), 32'hF0);
    errs = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      if (out_data !== 8'hF0 || dut.lfsr !== 16'h00F0 || out_valid !== 1'b1) errs++;
    end
    chk("stall_hold", errs, 0);
    out_ready = 1;
    wait_valid(50, n);
    chk("stall_w2", 32'(out_data), 32'hF6);
    do_reset();
    mode = 1; out_ready = 1; en = 1; step = 1;
    cyc(1);
    step = 0;
    chk("step_busy", 32'(busy), 1);
    cyc(2);
    step = 1;
    cyc(1);
    step = 0;
    wait_valid(50, n);
    chk("step_w1", 32'(out_data), 32'hF0);
    errs = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      if (out_valid !== 1'b0 || busy !== 1'b0) errs++;
    end
    chk("step_idle", errs, 0);
    step = 1;
    cyc(1);
    step = 0;
    wait_valid(50, n);
    chk("step_w2", 32'(out_data), 32'hF6);
    do_reset();
    cfg_seed = 16'hFFFF; cfg_load = 1;
    cyc(1);
    cfg_load = 0;
    chk("lock_state", 32'(dut.lfsr), 0);
    chk("lock_pulse", 32'(lock_err), 1);
    cyc(1);
    chk("lock_end", 32'(lock_err), 0);
    do_reset();
    out_ready = 1; en = 1;
    cyc(4);
    cfg_seed = 16'h1234; cfg_load = 1;
    cyc(1);
    cfg_load = 0;
    chk("load_state", 32'(dut.lfsr), 32'h1234);
    chk("load_nolock", 32'(lock_err), 0);
    chk("load_idle", 32'(busy), 0);
    wait_valid(50, n);
    chk("load_lat", n, 9);
    chk("load_word", 32'(out_data), 32'h19);
    chk("load_state8", 32'(dut.lfsr), 32'h3419);
    do_reset();
    en = 1;
    cyc(4);
    rst = 0;
    #1;
    chk("arst_gen_busy", 32'(busy), 0);
    chk("arst_gen_state", 32'(dut.lfsr), 0);
    en = 0;
    #2;
    rst = 1;
    cyc(1);
    en = 1;
    wait_valid(50, n);
    rst = 0;
    #1;
    chk("arst_hold_valid", 32'(out_valid), 0);
    chk("arst_hold_data", 32'(out_data), 0);
    do_reset();
    en = 1;
    cyc(5);
    chk("en0_pre_busy", 32'(busy), 1);
    en = 0;
    cyc(5);
    chk("en0_state", 32'(dut.lfsr), 32'h000F);
    chk("en0_busy", 32'(busy), 0);
    chk("en0_valid", 32'(out_valid), 0);
    en = 1;
    wait_valid(50, n);
    chk("en0_resume_lat", n, 9);
    chk("en0_resume_word", 32'(out_data), 32'h0F);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/lfsr_prng_core.md
Name: lfsr_prng_core

Overview:
- Parametrised Galois-free Fibonacci LFSR pseudo-random word generator with a built-in tick prescaler, seed load, lock-up recovery and a valid/ready output port.
- Successor to the fixed 8/16-bit LFSR pair.
  - No derived clocks: everything runs on CLK.
  - Rate is set by a clock-enable prescaler.
- Feeds display/mux logic or any consumer through the valid/ready handshake.

Parameters:
- WIDTH, 16: LFSR state width, 4..32.
- TAPS, 16'hD008: feedback tap mask, bit i set means state[i] is in the XNOR. Default is taps 15,14,12,3.
- OUT_W, 8: output word width, 1..WIDTH. Also the number of shifts per word.
- DIV_W, 24: prescaler counter width.
- SEED, 0: reset/recovery state, WIDTH bits. Must not be all-ones.

Ports:
- CLK, in, 1: clock.
- rst, in, 1: asynchronous active-low reset.
- en, in, 1: synchronous run enable.
- mode, in, 1: 0 = free-run, 1 = single-step.
- step, in, 1: in step mode, request one word (pulse).
- cfg_div, in, DIV_W: tick period minus 1.
- cfg_load, in, 1: load cfg_seed (pulse).
- cfg_seed, in, WIDTH: seed value.
- out_data, out, OUT_W: random word.
- out_valid, out, 1: out_data valid.
- out_ready, in, 1: consumer accepts.
- lock_err, out, 1: one-cycle pulse when an all-ones state was replaced.
- busy, out, 1: word generation in progress.

Behaviour:
- Reset (rst=0, async): state=SEED, prescaler=0, bit_cnt=0, FSM=IDLE, out_data=0, out_valid=0, lock_err=0, busy=0.
- Feedback: fb = ~^(state & TAPS). Shift: state <= {state[WIDTH-2:0], fb}. XNOR form makes all-zero legal; all-ones is the lock-up state.
- Prescaler: counts 0..cfg_div. tick=1 in the cycle count==cfg_div, and count wraps to 0 that cycle.
  - cfg_div=0 gives a tick every cycle.
  - Counts only in GEN state. Cleared on entry to GEN.
  - cfg_div changes take effect on the next compare.
- FSM states:
  - IDLE:
    - To GEN when en=1 and (mode=0, or mode=1 and step=1).
    - step is ignored outside IDLE.
  - GEN (busy=1):
    - Each tick shifts state once and increments bit_cnt.
    - On the tick where bit_cnt==OUT_W-1: out_data <= next_state[OUT_W-1:0], out_valid <= 1 (registered), bit_cnt <= 0, go to HOLD.
  - HOLD (busy=0):
    - out_valid=1 and out_data stable; state and prescaler frozen.
    - When out_valid & out_ready: out_valid <= 0 next cycle.
    - Then go to GEN if en=1 and mode=0, else to IDLE.
- Latency: with cfg_div=D, the first out_valid rises (OUT_W·(D+1))+1 cycles after the en/step cycle.
  - Back-to-back words in free-run with ready tied high: one bubble cycle between words.
- en=0: any state goes to IDLE next cycle.
  - out_valid cleared, prescaler and bit_cnt cleared.
  - LFSR state retained.
- cfg_load: highest priority below reset.
  - state <= cfg_seed; bit_cnt, prescaler, out_valid cleared.
  - FSM to IDLE (re-arms from IDLE next cycle if en conditions hold).
  - If cfg_load and tick coincide, the load wins and no shift occurs.
- Lock-up guard: if the value about to be written to state (load or shift) is all-ones, write SEED instead and pulse lock_err for 1 cycle.
- Wrap-around: maximal-length TAPS gives period 2^WIDTH−1. The guard only fires for a bad seed or bad TAPS.

Decomposition:
- Package prng_pkg holds:
  - The FSM enum (IDLE, GEN, HOLD).
  - Default tap constants for widths 8 (8'hB8), 16 (16'hD008), 24 and 32.
  - A function all_ones(width).
- One sub-module: prng_prescaler (CLK, rst, clr, run, cfg_div → tick).

Test Plan:
- Reset release, en=1, mode=0, cfg_div=0, ready=1, defaults:
  - first word out_data=0xF0, out_valid rising at cycle 9 after en;
  - second word 0xF6 (state 0xF0F6).
- cfg_div=3, same setup → first out_valid at cycle 33; state changes only every 4th cycle.
- out_ready=0 after first word:
  - out_data holds 0xF0 and state holds 0x00F0 for 20 cycles;
  - ready=1 → handshake, next word 0xF6.
- mode=1:
  - one step pulse → exactly one word 0xF0, then IDLE;
  - a step during GEN is ignored;
  - a second step after the handshake → 0xF6.
- cfg_load with cfg_seed=0xFFFF → state=0x0000 and lock_err high for 1 cycle. cfg_load with 0x1234 mid-GEN → bit_cnt restarts, no word from the partial run.
- Assert rst low mid-GEN and while out_valid=1 → all outputs zero immediately (async), state=SEED. en=0 mid-GEN → IDLE, state retained.
